// File: rtl/multicycle_datapath.sv
// multicycle_datapath: multicycle 24-bit (parametrised) processor core with an
// internal FSM and register file. One shared memory port carries both
// instruction fetch and data access using a req/ready handshake.
// Optional feature macro: MULTICYCLE_PERF_EN enables the 32-bit cycle and
// retired-instruction counters on perf_cycles/perf_instrs; without it both
// ports are tied to zero.
module multicycle_datapath #(
  parameter int                    DATA_WIDTH = 24,
  parameter int                    REG_COUNT  = 16,
  parameter logic [DATA_WIDTH-1:0] PC_RESET   = DATA_WIDTH'(10),
  parameter int                    PC_STEP    = DATA_WIDTH / 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [3:0]            opcode,
  output logic                  retired,
  output logic                  halted,
  output logic                  illegal,
  output logic [31:0]           perf_cycles,
  output logic [31:0]           perf_instrs
);

  localparam int W = DATA_WIDTH;

  localparam logic [3:0] OP_R    = 4'd0;
  localparam logic [3:0] OP_ADDI = 4'd1;
  localparam logic [3:0] OP_LW   = 4'd2;
  localparam logic [3:0] OP_SW   = 4'd3;
  localparam logic [3:0] OP_BEQ  = 4'd4;
  localparam logic [3:0] OP_BNE  = 4'd5;
  localparam logic [3:0] OP_JMP  = 4'd6;
  localparam logic [3:0] OP_HALT = 4'd15;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t state, state_next;

  logic [W-1:0] ir, a_reg, b_reg, alu_out, mdr;
  logic [W-1:0] regs [REG_COUNT];

  logic [3:0]   op, rs, rt, rd, funct, dest;
  logic [W-1:0] imm, jump_target, pc_seq, branch_target, mem_ea;
  logic [W-1:0] rf_a, rf_b, alu_res, wb_data;
  logic [4:0]   shamt;
  logic         shift_oor, branch_taken, illegal_instr;

  // Instruction field extraction from the latched IR
  assign op    = ir[W-1:W-4];
  assign rs    = ir[W-5:W-8];
  assign rt    = ir[W-9:W-12];
  assign rd    = ir[W-13:W-16];
  assign funct = ir[3:0];
  assign opcode = op;

  assign imm         = {{12{ir[W-13]}}, ir[W-13:0]};
  assign jump_target = {4'b0000, ir[W-5:0]};
  assign pc_seq        = pc + W'(PC_STEP);
  assign branch_target = pc_seq + imm;
  assign mem_ea        = a_reg + imm;

  // R-type uses rd as destination, ADDI/LW use rt
  assign dest    = (op == OP_R) ? rd : rt;
  assign wb_data = (op == OP_LW) ? mdr : alu_out;

  // r0 is hardwired to zero on the read side as well
  assign rf_a = (rs == 4'd0) ? '0 : regs[rs];
  assign rf_b = (rt == 4'd0) ? '0 : regs[rt];

  assign branch_taken  = (op == OP_BEQ) ? (a_reg == b_reg) : (a_reg != b_reg);
  assign illegal_instr = !(op inside {OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ,
                                      OP_BNE, OP_JMP, OP_HALT})
                         || ((op == OP_R) && funct[3]);

  assign shamt     = b_reg[4:0];
  assign shift_oor = (32'(shamt) >= 32'(DATA_WIDTH));

  // ALU: R-type by funct, everything else computes A + imm (ADDI)
  always_comb begin
    alu_res = '0;
    if (op == OP_R) begin
      case (funct)
        4'd0:    alu_res = a_reg + b_reg;
        4'd1:    alu_res = a_reg - b_reg;
        4'd2:    alu_res = a_reg & b_reg;
        4'd3:    alu_res = a_reg | b_reg;
        4'd4:    alu_res = a_reg ^ b_reg;
        4'd5:    alu_res = ($signed(a_reg) < $signed(b_reg)) ? W'(1) : '0;
        4'd6:    alu_res = shift_oor ? '0 : (a_reg << shamt);
        4'd7:    alu_res = shift_oor ? '0 : (a_reg >> shamt);
        default: alu_res = '0;
      endcase
    end else begin
      alu_res = a_reg + imm;
    end
  end

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) state <= S_FETCH;
    else       state <= state_next;
  end

  // Next-state logic; illegal instructions take the WB slot as a NOP
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  if (mem_ready) state_next = S_DECODE;
      S_DECODE: state_next = S_EXEC;
      S_EXEC: begin
        if (illegal_instr) begin
          state_next = S_WB;
        end else begin
          case (op)
            OP_LW, OP_SW:           state_next = S_MEM;
            OP_BEQ, OP_BNE, OP_JMP: state_next = S_FETCH;
            OP_HALT:                state_next = S_HALT;
            default:                state_next = S_WB;
          endcase
        end
      end
      S_MEM:    if (mem_ready) state_next = (op == OP_LW) ? S_WB : S_FETCH;
      S_WB:     state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_FETCH;
    endcase
  end

  // Outputs decoded from state; forced quiet while Reset is held
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    retired   = 1'b0;
    halted    = 1'b0;
    illegal   = 1'b0;
    if (!Reset) begin
      case (state)
        S_FETCH: begin
          mem_req  = 1'b1;
          mem_addr = pc;
        end
        S_EXEC: begin
          illegal = illegal_instr;
          retired = !illegal_instr && (op inside {OP_BEQ, OP_BNE, OP_JMP});
        end
        S_MEM: begin
          mem_req   = 1'b1;
          mem_we    = (op == OP_SW);
          mem_addr  = mem_ea;
          mem_wdata = b_reg;
          retired   = (op == OP_SW) && mem_ready;
        end
        S_WB:    retired = 1'b1;
        S_HALT:  halted  = 1'b1;
        default: ;
      endcase
    end
  end

  // Datapath registers: PC, IR, operand latches, ALU result and MDR
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc      <= PC_RESET;
      ir      <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      alu_out <= '0;
      mdr     <= '0;
    end else begin
      case (state)
        S_FETCH:  if (mem_ready) ir <= mem_rdata;
        S_DECODE: begin
          a_reg <= rf_a;
          b_reg <= rf_b;
        end
        S_EXEC: begin
          alu_out <= alu_res;
          if (!illegal_instr) begin
            if (op == OP_BEQ || op == OP_BNE)
              pc <= branch_taken ? branch_target : pc_seq;
            else if (op == OP_JMP)
              pc <= jump_target;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            if (op == OP_LW) mdr <= mem_rdata;
            else             pc  <= pc_seq;
          end
        end
        S_WB:    pc <= pc_seq;
        default: ;
      endcase
    end
  end

  // Register file write port; r0 writes and illegal NOPs are dropped
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (state == S_WB && !illegal_instr && dest != 4'd0) begin
      regs[dest] <= wb_data;
    end
  end

`ifdef MULTICYCLE_PERF_EN
  logic [31:0] cycle_cnt, instr_cnt;

  // Free-running counters that freeze in HALT and wrap at 2^32
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (state != S_HALT) cycle_cnt <= cycle_cnt + 32'd1;
      if (retired)         instr_cnt <= instr_cnt + 32'd1;
    end
  end

  assign perf_cycles = cycle_cnt;
  assign perf_instrs = instr_cnt;
`else
  assign perf_cycles = 32'd0;
  assign perf_instrs = 32'd0;
`endif

endmodule
